sifreleme_hakem: RTL and testbench

Round-robin arbiter and sequencer that shares one serial encryption engine between ISTEMCI requesters. It latches the granted requester's operands, pulses the engine start line and deserialises the engine's LSB-first bit stream back into a BIT-wide word. It returns the result to the granted requester with a one-cycle onay pulse. It sits between the requester blocks and the engine; the engine uses the same saat and reset.

---
 rtl/sifreleme_pkg.sv | 23 ++
 rtl/sifreleme_rr_secici.sv | 37 +++
 rtl/sifreleme_hakem.sv | 149 ++++++++++++++
 tb/tb_sifreleme_hakem.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sifreleme_pkg.sv
// Shared types and helpers for the encryption-engine arbiter: state encoding,
// key-select width and a width helper for index and counter sizing.
package sifreleme_pkg;

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        BASLAT = 2'd1,
        BEKLE  = 2'd2,
        TESLIM = 2'd3
    } durum_t;

    localparam int SECIM_W = 3;

    // Minimum 1 so that single-value ranges still get a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/sifreleme_rr_secici.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping explicitly so non-power-of-two requester counts work.
module sifreleme_rr_secici
    import sifreleme_pkg::*;
#(
    parameter int ISTEMCI = 4,
    parameter int IDX_W   = 2
) (
    input  logic [ISTEMCI-1:0] istek,
    input  logic [IDX_W-1:0]   pointer,
    output logic               gecerli_secim,
    output logic [IDX_W-1:0]   secilen_index
);

    logic [2*ISTEMCI-1:0] cift;
    logic [ISTEMCI-1:0]   donmus;
    logic [IDX_W:0]       toplam;

    always_comb begin
        gecerli_secim = 1'b0;
        secilen_index = '0;
        toplam        = '0;
        // Rotating the doubled vector puts the pointer's requester at bit 0.
        cift   = {istek, istek} >> pointer;
        donmus = cift[ISTEMCI-1:0];
        for (int k = ISTEMCI - 1; k >= 0; k--) begin
            if (donmus[k]) begin
                toplam = {1'b0, pointer} + (IDX_W + 1)'(k);
                if (toplam >= (IDX_W + 1)'(ISTEMCI))
                    toplam = toplam - (IDX_W + 1)'(ISTEMCI);
                gecerli_secim = 1'b1;
                secilen_index = toplam[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sifreleme_hakem.sv
// Round-robin arbiter/sequencer sharing one serial encryption engine: latches the
// winner's operands, starts the engine, gathers its LSB-first bits and returns them.
module sifreleme_hakem
    import sifreleme_pkg::*;
#(
    parameter int BIT         = 4,
    parameter int ISTEMCI     = 4,
    parameter int ZAMAN_ASIMI = 16
) (
    input  logic                       saat,
    input  logic                       reset,
    input  logic [ISTEMCI-1:0]         istek,
    input  logic [ISTEMCI*BIT-1:0]     istek_veri,
    input  logic [ISTEMCI-1:0]         istek_mod,
    input  logic [ISTEMCI*SECIM_W-1:0] istek_secim,
    output logic [ISTEMCI-1:0]         onay,
    output logic [BIT-1:0]             sonuc,
    output logic                       hata,
    output logic                       mesgul,
    output logic                       m_basla,
    output logic                       m_mod,
    output logic [BIT-1:0]             m_veri,
    output logic [SECIM_W-1:0]         m_secim,
    input  logic                       m_bit,
    input  logic                       m_gecerli
);

    localparam int IDX_W = clog2(ISTEMCI);
    localparam int BC_W  = clog2(BIT + 1);
    localparam int ZC_W  = clog2(ZAMAN_ASIMI + 1);

    localparam logic [ISTEMCI-1:0] TEK_ONAY = {{(ISTEMCI - 1){1'b0}}, 1'b1};

    durum_t              durum;
    logic [IDX_W-1:0]    pointer;
    logic [IDX_W-1:0]    secili;
    logic [BC_W-1:0]     bit_cnt;
    logic [ZC_W-1:0]     zaman_cnt;
    logic [BIT-1:0]      kaydirma;

    logic                gecerli_secim;
    logic [IDX_W-1:0]    secilen_index;
    logic [BIT-1:0]      sec_veri;
    logic                sec_mod;
    logic [SECIM_W-1:0]  sec_secim;
    logic [BIT-1:0]      yeni_kayit;
    logic                son_bit;
    logic                zaman_doldu;

    sifreleme_rr_secici #(
        .ISTEMCI (ISTEMCI),
        .IDX_W   (IDX_W)
    ) u_rr_secici (
        .istek         (istek),
        .pointer       (pointer),
        .gecerli_secim (gecerli_secim),
        .secilen_index (secilen_index)
    );

    always_comb begin
        sec_veri  = '0;
        sec_mod   = 1'b0;
        sec_secim = '0;
        for (int i = 0; i < ISTEMCI; i++) begin
            if (secilen_index == IDX_W'(i)) begin
                sec_veri  = istek_veri[i*BIT +: BIT];
                sec_mod   = istek_mod[i];
                sec_secim = istek_secim[i*SECIM_W +: SECIM_W];
            end
        end
    end

    // Shift register is cleared in BASLAT, so OR-ing the new bit in is a write.
    assign yeni_kayit  = kaydirma | ({{(BIT - 1){1'b0}}, m_bit} << bit_cnt);
    assign son_bit     = m_gecerli && (bit_cnt == BC_W'(BIT - 1));
    assign zaman_doldu = (zaman_cnt == ZC_W'(ZAMAN_ASIMI - 1));

    always_ff @(posedge saat) begin
        if (reset) begin
            durum     <= BOSTA;
            pointer   <= '0;
            secili    <= '0;
            bit_cnt   <= '0;
            zaman_cnt <= '0;
            kaydirma  <= '0;
            onay      <= '0;
            sonuc     <= '0;
            hata      <= 1'b0;
            mesgul    <= 1'b0;
            m_basla   <= 1'b0;
            m_mod     <= 1'b0;
            m_veri    <= '0;
            m_secim   <= '0;
        end else begin
            onay    <= '0;
            m_basla <= 1'b0;
            case (durum)
                BOSTA: begin
                    if (gecerli_secim) begin
                        secili  <= secilen_index;
                        m_veri  <= sec_veri;
                        m_mod   <= sec_mod;
                        m_secim <= sec_secim;
                        if (secilen_index == IDX_W'(ISTEMCI - 1))
                            pointer <= '0;
                        else
                            pointer <= secilen_index + 1'b1;
                        m_basla <= 1'b1;
                        mesgul  <= 1'b1;
                        durum   <= BASLAT;
                    end
                end
                BASLAT: begin
                    bit_cnt   <= '0;
                    zaman_cnt <= '0;
                    kaydirma  <= '0;
                    durum     <= BEKLE;
                end
                BEKLE: begin
                    zaman_cnt <= zaman_cnt + 1'b1;
                    if (m_gecerli) begin
                        kaydirma <= yeni_kayit;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                    // A completed word wins over a timeout landing on the same cycle.
                    if (son_bit) begin
                        sonuc <= yeni_kayit;
                        hata  <= 1'b0;
                        onay  <= TEK_ONAY << secili;
                        durum <= TESLIM;
                    end else if (zaman_doldu) begin
                        sonuc <= '0;
                        hata  <= 1'b1;
                        onay  <= TEK_ONAY << secili;
                        durum <= TESLIM;
                    end
                end
                TESLIM: begin
                    sonuc  <= '0;
                    hata   <= 1'b0;
                    mesgul <= 1'b0;
                    durum  <= BOSTA;
                end
                default: durum <= BOSTA;
            endcase
        end
    end

endmodule

// File: tb/tb_sifreleme_hakem.sv
// Scoreboard bench for sifreleme_hakem with a behavioural serial engine model:
// enc = rotl1(v) ^ key, dec = rotr1(v) ^ key, key = {secim, 1'b1}.
module tb_sifreleme_hakem;

    localparam int BIT         = 4;
    localparam int ISTEMCI     = 4;
    localparam int ZAMAN_ASIMI = 16;

    logic                 saat;
    logic                 reset;
    logic [ISTEMCI-1:0]   istek;
    logic [ISTEMCI*BIT-1:0] istek_veri;
    logic [ISTEMCI-1:0]   istek_mod;
    logic [ISTEMCI*3-1:0] istek_secim;
    logic [ISTEMCI-1:0]   onay;
    logic [BIT-1:0]       sonuc;
    logic                 hata;
    logic                 mesgul;
    logic                 m_basla;
    logic                 m_mod;
    logic [BIT-1:0]       m_veri;
    logic [2:0]           m_secim;
    logic                 m_bit;
    logic                 m_gecerli;

    typedef struct {
        logic [3:0] onay;
        logic [3:0] sonuc;
        logic       hata;
        int         cyc;
    } beklenen_t;

    beklenen_t kuyruk[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int basla_sayisi = 0;
    bit motor_acik = 1'b1;

    sifreleme_hakem #(
        .BIT         (BIT),
        .ISTEMCI     (ISTEMCI),
        .ZAMAN_ASIMI (ZAMAN_ASIMI)
    ) dut (
        .saat        (saat),
        .reset       (reset),
        .istek       (istek),
        .istek_veri  (istek_veri),
        .istek_mod   (istek_mod),
        .istek_secim (istek_secim),
        .onay        (onay),
        .sonuc       (sonuc),
        .hata        (hata),
        .mesgul      (mesgul),
        .m_basla     (m_basla),
        .m_mod       (m_mod),
        .m_veri      (m_veri),
        .m_secim     (m_secim),
        .m_bit       (m_bit),
        .m_gecerli   (m_gecerli)
    );

    initial begin
        saat = 1'b0;
        forever #5 saat = ~saat;
    end

    initial forever begin
        @(posedge saat);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", ad, gercek, beklenen, cyc);
        end
    endtask

    function automatic logic [3:0] motor(input logic [3:0] v, input logic md, input logic [2:0] s);
        logic [3:0] k;
        k = {s, 1'b1};
        return md ? ({v[2:0], v[3]} ^ k) : ({v[0], v[3:1]} ^ k);
    endfunction

    // Engine model: bits on the 2nd..(BIT+1)th cycle after the m_basla cycle.
    initial begin
        logic [3:0] r;
        m_bit = 1'b0;
        m_gecerli = 1'b0;
        forever begin
            @(negedge saat);
            if (m_basla && motor_acik && !reset) begin
                r = motor(m_veri, m_mod, m_secim);
                @(posedge saat);
                @(posedge saat);
                for (int i = 0; i < BIT; i++) begin
                    #1;
                    if (reset) break;
                    m_bit = r[i];
                    m_gecerli = 1'b1;
                    @(posedge saat);
                end
                #1;
                m_gecerli = 1'b0;
                m_bit = 1'b0;
            end
        end
    end

    // Monitor: every onay pulse is matched against the head of the scoreboard.
    initial begin
        beklenen_t b;
        forever begin
            @(negedge saat);
            if (m_basla) basla_sayisi++;
            if (onay != '0) begin
                if (kuyruk.size() == 0) begin
                    kontrol("beklenmeyen_onay", 32'(onay), 32'h0);
                end else begin
                    b = kuyruk.pop_front();
                    kontrol("onay", 32'(onay), 32'(b.onay));
                    kontrol("sonuc", 32'(sonuc), 32'(b.sonuc));
                    kontrol("hata", 32'(hata), 32'(b.hata));
                    kontrol("onay_zamani", 32'(cyc), 32'(b.cyc));
                end
            end
        end
    end

    task automatic ekle(input logic [3:0] o, input logic [3:0] s, input logic h, input int c);
        beklenen_t b;
        b.onay = o;
        b.sonuc = s;
        b.hata = h;
        b.cyc = c;
        kuyruk.push_back(b);
    endtask

    task automatic ayarla(input int i, input logic [3:0] v, input logic md, input logic [2:0] s);
        istek_veri[i*4 +: 4] = v;
        istek_mod[i] = md;
        istek_secim[i*3 +: 3] = s;
    endtask

    task automatic bosalt();
        int n;
        n = 0;
        while (kuyruk.size() != 0 && n < 300) begin
            @(negedge saat);
            n++;
        end
        kontrol("kuyruk_bosaldi", 32'(kuyruk.size()), 32'h0);
    endtask

    task automatic sifir_kontrol(input string ad);
        kontrol(ad, 32'({onay, sonuc, hata, mesgul, m_basla, m_mod, m_veri, m_secim}), 32'h0);
    endtask

    task automatic sifirla();
        @(negedge saat);
        reset = 1'b1;
        istek = '0;
        @(negedge saat);
        reset = 1'b0;
    endtask

    initial begin
        int T;
        int b0;
        reset = 1'b1;
        istek = '0;
        istek_veri = '0;
        istek_mod = '0;
        istek_secim = '0;
        repeat (3) @(negedge saat);
        sifir_kontrol("reset_durumu");
        kontrol("reset_mesgul", 32'(mesgul), 32'h0);
        reset = 1'b0;

        // 1: encrypt 6 with key 1 -> D, onay at T+7
        ayarla(0, 4'h6, 1'b1, 3'd0);
        @(negedge saat);
        T = cyc;
        b0 = basla_sayisi;
        istek = 4'b0001;
        ekle(4'b0001, 4'hD, 1'b0, T + 7);
        @(negedge saat);
        kontrol("m_basla_t1", 32'(m_basla), 32'h1);
        kontrol("m_veri_t1", 32'(m_veri), 32'h6);
        kontrol("m_mod_t1", 32'(m_mod), 32'h1);
        kontrol("mesgul_t1", 32'(mesgul), 32'h1);
        @(negedge saat);
        kontrol("m_basla_t2", 32'(m_basla), 32'h0);
        repeat (5) @(negedge saat);
        istek = '0;
        bosalt();
        repeat (3) @(negedge saat);
        kontrol("mesgul_bitti", 32'(mesgul), 32'h0);
        kontrol("tek_basla_t1", 32'(basla_sayisi - b0), 32'h1);

        // 2: decrypt 6 with key 1 -> 2
        ayarla(0, 4'h6, 1'b0, 3'd0);
        @(negedge saat);
        T = cyc;
        istek = 4'b0001;
        ekle(4'b0001, 4'h2, 1'b0, T + 7);
        repeat (7) @(negedge saat);
        istek = '0;
        bosalt();

        // 3: 1011 held from pointer 0 -> order 0,1,3,0,1,3 eight cycles apart
        sifirla();
        ayarla(0, 4'h6, 1'b1, 3'd0);
        ayarla(1, 4'h3, 1'b0, 3'd2);
        ayarla(3, 4'hA, 1'b1, 3'd3);
        @(negedge saat);
        T = cyc;
        istek = 4'b1011;
        ekle(4'b0001, 4'hD, 1'b0, T + 7);
        ekle(4'b0010, 4'hC, 1'b0, T + 15);
        ekle(4'b1000, 4'h2, 1'b0, T + 23);
        ekle(4'b0001, 4'hD, 1'b0, T + 31);
        ekle(4'b0010, 4'hC, 1'b0, T + 39);
        ekle(4'b1000, 4'h2, 1'b0, T + 47);
        repeat (47) @(negedge saat);
        istek = '0;
        bosalt();

        // 4: silent engine -> timeout after 16 BEKLE cycles, hata=1, sonuc=0
        motor_acik = 1'b0;
        @(negedge saat);
        T = cyc;
        istek = 4'b0010;
        ekle(4'b0010, 4'h0, 1'b1, T + 18);
        repeat (18) @(negedge saat);
        istek = '0;
        bosalt();
        @(negedge saat);
        kontrol("mesgul_zaman_asimi", 32'(mesgul), 32'h0);
        motor_acik = 1'b1;

        // 5: reset after two captured bits aborts silently and rewinds the pointer
        @(negedge saat);
        T = cyc;
        istek = 4'b0010;
        repeat (5) @(negedge saat);
        reset = 1'b1;
        istek = '0;
        @(negedge saat);
        sifir_kontrol("reset_iptal");
        reset = 1'b0;
        repeat (12) @(negedge saat);
        kontrol("iptal_mesgul", 32'(mesgul), 32'h0);
        ayarla(0, 4'h6, 1'b1, 3'd0);
        ayarla(2, 4'h9, 1'b1, 3'd4);
        @(negedge saat);
        T = cyc;
        istek = 4'b0101;
        ekle(4'b0001, 4'hD, 1'b0, T + 7);
        ekle(4'b0100, 4'hA, 1'b0, T + 15);
        repeat (7) @(negedge saat);
        istek = 4'b0100;
        repeat (8) @(negedge saat);
        istek = '0;
        bosalt();

        // 6: request dropped right after grant still completes, only once
        ayarla(3, 4'hC, 1'b0, 3'd5);
        @(negedge saat);
        T = cyc;
        b0 = basla_sayisi;
        istek = 4'b1000;
        ekle(4'b1000, 4'hD, 1'b0, T + 7);
        @(negedge saat);
        istek = '0;
        bosalt();
        repeat (10) @(negedge saat);
        kontrol("tek_basla_t6", 32'(basla_sayisi - b0), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
